alu_muldiv_seq: RTL and testbench

- Iterative unsigned multiply/divide sequencer for the multi-cycle processor.
- Acts as the initiator on the 32-bit ALU's operand/control interface: drives A, B and the 3-bit control code, and consumes the ALU result and carry flag each cycle.
- Performs W-step shift-add multiplication and restoring division using the ALU as its only adder/subtractor.
- Exposes a start/busy/done handshake to the control unit.

---
 rtl/alu_muldiv_seq_pkg.sv | 17 +
 rtl/alu_muldiv_seq.sv | 113 +++++++++++
 tb/tb_alu_muldiv_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer and the datapath that hosts its ALU.
package alu_muldiv_seq_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_CLR = 3'b111;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned shift-add multiply / restoring divide, one step per cycle through the external ALU.
// W+1 cycles from accepted start to done; start is ignored outside IDLE.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic         div_by_zero,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_control,
  input  logic [W-1:0] alu_out,
  input  logic         alu_c
);

  state_t        state, state_nxt;
  logic          op_q;
  logic [W-1:0]  hi, lo, d;
  logic [CW-1:0] cnt;
  logic          last;
  logic          sub_ok;
  logic          accept;

  assign last   = (cnt == CW'(W-1));
  assign accept = (state == IDLE) && start;
  // The bit shifted out of hi makes the shifted remainder >= 2^W, so it always exceeds D.
  assign sub_ok = hi[W-1] | alu_c;

  assign res_hi = hi;
  assign res_lo = lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (op == OP_DIV && opb == '0) ? DONE : RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == RUN);
    done        = (state == DONE);
    alu_control = ALU_CLR;
    alu_a       = '0;
    alu_b       = '0;
    if (state == RUN) begin
      if (op_q == OP_MUL) begin
        alu_control = ALU_ADD;
        alu_a       = hi;
        alu_b       = lo[0] ? d : '0;
      end else begin
        alu_control = ALU_SUB;
        alu_a       = {hi[W-2:0], lo[W-1]};
        alu_b       = d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_MUL;
      hi          <= '0;
      lo          <= '0;
      d           <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_q        <= op;
      d           <= opb;
      cnt         <= '0;
      if (op == OP_DIV && opb == '0) begin
        hi          <= opa;
        lo          <= '1;
        div_by_zero <= 1'b1;
      end else begin
        hi          <= '0;
        lo          <= opa;
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      if (op_q == OP_MUL) begin
        hi <= {alu_c, alu_out[W-1:1]};
        lo <= {alu_out[0], lo[W-1:1]};
      end else if (sub_ok) begin
        hi <= alu_out;
        lo <= {lo[W-2:0], 1'b1};
      end else begin
        hi <= {hi[W-2:0], lo[W-1]};
        lo <= {lo[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq with a behavioural 32-bit ALU on the alu_* ports.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] opa, opb;
  logic         busy, done, div_by_zero;
  logic [W-1:0] res_hi, res_lo;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_control;
  logic         alu_c;
  logic [W:0]   alu_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU: add, A-B via A+~B+1 (carry=1 means no borrow), clear otherwise
  always_comb begin
    alu_sum = '0;
    case (alu_control)
      ALU_ADD: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: alu_sum = '0;
    endcase
  end
  assign alu_out = alu_sum[W-1:0];
  assign alu_c   = alu_sum[W];

  alu_muldiv_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo),
    .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_out(alu_out), .alu_c(alu_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts falling edges after the start edge until done; lat=-1 on timeout
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, dones;
    logic [W-1:0] ra, rb;
    logic [63:0]  prod;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res", {res_hi, res_lo}, 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_alu_ctl", 64'(alu_control), 64'd7);
    @(negedge clk) rst_n = 1'b1;

    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    chk("mul_max_lat", 64'(lat), 64'd33);
    chk("mul_max_busy", 64'(bc), 64'd32);
    chk("mul_max_res", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);

    issue(OP_DIV, 32'd100, 32'd7);
    wait_done(lat, bc);
    chk("div_100_7_lat", 64'(lat), 64'd33);
    chk("div_100_7_res", {res_hi, res_lo}, {32'd2, 32'd14});
    chk("div_100_7_dbz", 64'(div_by_zero), 64'd0);

    issue(OP_DIV, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(lat, bc);
    chk("div_msb_res", {res_hi, res_lo}, {32'h7FFF_FFFF, 32'd1});

    issue(OP_DIV, 32'h1234, 32'd0);
    wait_done(lat, bc);
    chk("dbz_lat", 64'(lat), 64'd1);
    chk("dbz_res", {res_hi, res_lo}, {32'h1234, 32'hFFFF_FFFF});
    chk("dbz_flag", 64'(div_by_zero), 64'd1);
    @(negedge clk);
    chk("dbz_hold", 64'(div_by_zero), 64'd1);

    issue(OP_MUL, 32'd3, 32'd5);
    wait_done(lat, bc);
    chk("mul_3_5_res", {res_hi, res_lo}, 64'd15);
    chk("mul_3_5_dbz", 64'(div_by_zero), 64'd0);

    // A start during RUN must not disturb the multiply in flight
    issue(OP_MUL, 32'd1234567, 32'd89);
    dones = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (n == 10) begin
        start = 1'b1; op = OP_DIV; opa = 32'd999; opb = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_res", {res_hi, res_lo}, 64'd109876463);
    chk("ign_dbz", 64'(div_by_zero), 64'd0);

    // Asynchronous abort mid-divide
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (12) @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    chk("abort_res", {res_hi, res_lo}, 64'd0);
    chk("abort_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("abort_alu_ctl", 64'(alu_control), 64'd7);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    rst_n = 1'b1;

    issue(OP_DIV, 32'd100, 32'd7);
    wait_done(lat, bc);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_res", {res_hi, res_lo}, {32'd2, 32'd14});

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = rb >> $urandom_range(31, 16);
      prod = 64'(ra) * 64'(rb);
      issue(OP_MUL, ra, rb);
      wait_done(lat, bc);
      chk("rnd_mul", {res_hi, res_lo}, prod);
      if (rb == '0) rb = 32'd1;
      issue(OP_DIV, ra, rb);
      wait_done(lat, bc);
      chk("rnd_div", {res_hi, res_lo}, {ra % rb, ra / rb});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
